// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle between the MEM stage, the debug/DMA port and the data memory.
// The arbiter takes the slave side; requesters and the memory take the master side.
interface dmem_port_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  p_req;
  logic                  p_we;
  logic [2:0]            p_funct3;
  logic [DM_ADDRESS-1:0] p_addr;
  logic [DATA_W-1:0]     p_wdata;
  logic                  p_gnt;
  logic                  p_stall;
  logic                  p_rvalid;
  logic [DATA_W-1:0]     p_rdata;
  logic                  p_err;

  logic                  d_req;
  logic                  d_we;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic [DM_ADDRESS-1:0] m_raddr;
  logic [DM_ADDRESS-1:0] m_waddr;
  logic [3:0]            m_wr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  p_req, p_we, p_funct3, p_addr, p_wdata,
    output p_gnt, p_stall, p_rvalid, p_rdata, p_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_raddr, m_waddr, m_wr, m_wdata,
    input  m_rdata
  );

  modport master (
    output p_req, p_we, p_funct3, p_addr, p_wdata,
    input  p_gnt, p_stall, p_rvalid, p_rdata, p_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_raddr, m_waddr, m_wr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester data-memory port: pipeline (all RV32I widths) and word-only debug port,
// with starvation-bounded pipeline priority and one-cycle read sequencing.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, P_RD, D_RD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;

  logic       d_win, p_win;
  logic       p_gnt_i, d_gnt_i;
  logic       p_mis;
  logic [1:0] a_lo;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [DATA_W-1:0] p_fmt;
  logic              unused_addr_lo;

  assign a_lo           = bus.p_addr[1:0];
  assign unused_addr_lo = &{1'b0, bus.d_addr[1:0]};

  // Undefined funct3 encodings are folded into the misaligned path.
  always_comb begin
    p_mis = 1'b1;
    case (bus.p_funct3)
      3'b000, 3'b100: p_mis = 1'b0;
      3'b001, 3'b101: p_mis = a_lo[0];
      3'b010:         p_mis = (a_lo != 2'b00);
      default:        p_mis = 1'b1;
    endcase
  end

  always_comb begin
    d_win   = bus.d_req & (~bus.p_req | (starve == STARVE_LIM));
    p_win   = bus.p_req & ~d_win;
    p_gnt_i = (state == IDLE) & ~reset & p_win;
    d_gnt_i = (state == IDLE) & ~reset & d_win;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (d_gnt_i && !bus.d_we)               state_nxt = D_RD;
        else if (p_gnt_i && !bus.p_we && !p_mis) state_nxt = P_RD;
        else                                     state_nxt = IDLE;
      end
      P_RD:    state_nxt = IDLE;
      D_RD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
      off_q  <= '0;
      f3_q   <= '0;
    end else begin
      if (d_gnt_i || !bus.d_req) starve <= '0;
      else if (p_gnt_i)          starve <= starve + CW'(1);
      if (p_gnt_i && !bus.p_we) begin
        off_q <= a_lo;
        f3_q  <= bus.p_funct3;
      end
    end
  end

  // Load lane selection and extension from the registered offset/width.
  always_comb begin
    case (off_q)
      2'd0:    rbyte = bus.m_rdata[7:0];
      2'd1:    rbyte = bus.m_rdata[15:8];
      2'd2:    rbyte = bus.m_rdata[23:16];
      default: rbyte = bus.m_rdata[31:24];
    endcase
    rhalf = off_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    case (f3_q)
      3'b000:  p_fmt = {{(DATA_W-8){rbyte[7]}}, rbyte};
      3'b100:  p_fmt = {{(DATA_W-8){1'b0}}, rbyte};
      3'b001:  p_fmt = {{(DATA_W-16){rhalf[15]}}, rhalf};
      3'b101:  p_fmt = {{(DATA_W-16){1'b0}}, rhalf};
      3'b010:  p_fmt = bus.m_rdata;
      default: p_fmt = '0;
    endcase
  end

  // Output logic
  always_comb begin
    bus.p_gnt    = p_gnt_i;
    bus.d_gnt    = d_gnt_i;
    bus.p_stall  = bus.p_req & ~p_gnt_i;
    bus.p_err    = p_gnt_i & p_mis;
    bus.p_rvalid = (state == P_RD);
    bus.d_rvalid = (state == D_RD);
    bus.p_rdata  = bus.p_rvalid ? p_fmt : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

    bus.m_raddr  = d_gnt_i ? {bus.d_addr[DM_ADDRESS-1:2], 2'b00} : bus.p_addr;
    bus.m_waddr  = {bus.m_raddr[DM_ADDRESS-1:2], 2'b00};

    bus.m_wdata  = bus.p_wdata;
    if (d_gnt_i) begin
      bus.m_wdata = bus.d_wdata;
    end else begin
      case (bus.p_funct3[1:0])
        2'b00:   bus.m_wdata = {4{bus.p_wdata[7:0]}};
        2'b01:   bus.m_wdata = {2{bus.p_wdata[15:0]}};
        default: bus.m_wdata = bus.p_wdata;
      endcase
    end

    bus.m_wr = 4'b0000;
    if (d_gnt_i && bus.d_we) begin
      bus.m_wr = 4'b1111;
    end else if (p_gnt_i && bus.p_we && !p_mis) begin
      case (bus.p_funct3[1:0])
        2'b00:   bus.m_wr = 4'b0001 << a_lo;
        2'b01:   bus.m_wr = a_lo[1] ? 4'b1100 : 4'b0011;
        default: bus.m_wr = 4'b1111;
      endcase
    end
  end

endmodule
